spi_master_shifter: RTL
=======================

# spi_master_shifter

SPI master transfer engine for the SPI block. It takes a parallel transmit word and a start strobe, then drives chip-select, SCK and MOSI, samples MISO, and returns the received word with a one-cycle done pulse. It sits between the register/CPU side and the SPI pins. It owns SCK generation per transfer: a programmable half-period counter with CPOL/CPHA edge classification.

## Interface
- DATA_WIDTH, 8, bits per transfer (N), MSB first
- DIV_WIDTH, 4, width of the half-period divide input
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- i_start  input  1  transfer request; sampled only in IDLE
- i_tx_data  input  DATA_WIDTH  word to send; latched on an accepted start
- i_cpol  input  1  SCK idle level; latched on start
- i_cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on start
- i_div  input  DIV_WIDTH  half-period H = i_div+1 clk cycles; latched on start
- i_miso  input  1  serial data from slave
- o_sclk  output  1  SPI clock
- o_mosi  output  1  serial data to slave
- o_cs_n  output  1  active-low chip select
- o_busy  output  1  high from SETUP through HOLD
- o_rx_data  output  DATA_WIDTH  last received word
- o_done  output  1  one-cycle pulse at transfer end

## Operation
- Reset values: o_cs_n=1, o_busy=0, o_done=0, o_rx_data=0, o_mosi=0, internal SCK register = 0, state = IDLE, all counters 0.
- FSM states are IDLE, SETUP, SHIFT and HOLD.
- IDLE: o_sclk follows i_cpol directly. If i_start=1, latch the inputs, load the TX shift register, and go to SETUP.
- SETUP: lasts H cycles. o_cs_n=0. o_mosi = tx MSB. SCK register = latched CPOL.
- SHIFT: a half-period counter runs 0..H-1. When it reaches H-1, SCK toggles and the edge index e (0..2N-1) advances. After the 2N-th toggle, SCK is back at CPOL and the FSM goes to HOLD.
- Edge classification: even e = leading edge, odd e = trailing edge.
- CPHA=0: sample i_miso on every leading edge. Shift TX on every trailing edge except the last one.
- CPHA=1: shift TX on every leading edge except the first one. Sample on every trailing edge.
- o_mosi is always the TX shift register MSB.
- Sampling: i_miso is captured on the same clk edge that drives SCK to the sampling level. It shifts into the RX register LSB-in, giving N samples in total.
- HOLD: lasts H cycles. o_cs_n stays 0 and SCK = CPOL. Then return to IDLE. In that IDLE-entry cycle: o_cs_n=1, o_busy=0, o_done=1, and o_rx_data is updated.
- o_rx_data holds its value until the next done.
- i_start while busy is ignored (not queued).
- i_start in the done cycle is accepted: back-to-back transfers are allowed.
- Changes to i_cpol/i_cpha/i_div/i_tx_data during a transfer have no effect.
- rst=0 at any point, including mid-transfer: on the next edge, apply reset values, abort the transfer, no o_done, o_rx_data=0.

## Timing
- Start sampled at edge 0 → o_busy=1 and o_cs_n=0 from cycle 1.
- SETUP = H cycles, SHIFT = 2N·H cycles, HOLD = H cycles.
- o_done occurs at cycle (2N+2)·H + 1 after the start edge.
- First SCK edge is at cycle 2H+1 after the start edge. Consecutive edges are H cycles apart.
- i_div=0 (H=1): SCK = clk/2, and every state still gets at least one cycle.
- Arithmetic: the half-period counter is DIV_WIDTH bits wide and compares against the latched i_div. The edge counter is ceil(log2(2N)) bits wide and wraps only via the state change.

## Test plan
- Mode 0, i_div=1, tx=0xA5, MISO looped to MOSI → rx=0xA5; exactly 8 rising SCK edges; o_done at cycle 37; o_cs_n low for cycles 1–36.
- Mode 3 (CPOL=1, CPHA=1), i_div=0, tx=0x3C, slave model returns 0x96 → rx=0x96; SCK idles high; MOSI changes only on falling edges; o_done at cycle 19.
- Modes 1 and 2, tx=0x81, slave returns 0x7E → rx=0x7E in both. The sample edge type matches CPHA, and no MOSI change coincides with a sample edge.
- i_start pulsed at cycles 5 and 20 of a running transfer → ignored. Exactly one o_done. i_start in the done cycle → second transfer starts; o_busy low for 1 cycle only.
- rst=0 at cycle 15 of a transfer → next cycle o_cs_n=1, o_busy=0, o_rx_data=0, o_done never pulses; a new start after reset completes normally.
- i_div=15, DATA_WIDTH=8, and i_div changed to 0 mid-transfer → H stays 16; o_done at cycle 289.

Source files
------------

// File: rtl/spi_master_shifter.sv
// spi_master_shifter: SPI master transfer engine.
// Takes a parallel word and a start strobe. It drives chip-select, SCK and MOSI, samples MISO
// and returns the received word together with a one-cycle done pulse. SCK is generated per
// transfer from a half-period counter. Each SCK edge is classified as leading or trailing
// using the latched CPOL/CPHA.
//
// Ports:
//   clk, rst     system clock (rising edge); synchronous active-low reset
//   i_start      transfer request, only sampled while idle
//   i_tx_data    word to send (MSB first), latched on an accepted start
//   i_cpol       SCK idle level, latched on start
//   i_cpha       0: sample on leading edge, 1: sample on trailing edge; latched on start
//   i_div        half-period H = i_div + 1 clk cycles, latched on start
//   i_miso       serial data from the slave
//   o_sclk       SPI clock
//   o_mosi       serial data to the slave (always the TX shift register MSB)
//   o_cs_n       active-low chip select
//   o_busy       high from SETUP through HOLD
//   o_rx_data    last received word, held until the next done
//   o_done       one-cycle pulse in the cycle the engine returns to idle
module spi_master_shifter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DIV_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_cpol,
   input  logic                  i_cpha,
   input  logic [DIV_WIDTH-1:0]  i_div,
   input  logic                  i_miso,
   output logic                  o_sclk,
   output logic                  o_mosi,
   output logic                  o_cs_n,
   output logic                  o_busy,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_done
);

   localparam int unsigned EdgeW = $clog2(2 * DATA_WIDTH);
   localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

   state_e                state_q;
   logic [DIV_WIDTH-1:0]  cnt_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [EdgeW-1:0]      edge_q;
   logic                  cpol_q;
   logic                  cpha_q;
   logic                  sclk_q;
   logic [DATA_WIDTH-1:0] tx_q;
   logic [DATA_WIDTH-1:0] rx_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  cs_n_q;
   logic                  busy_q;
   logic                  done_q;

   logic half_done;
   logic sample_edge;
   logic shift_edge;

   always_comb begin
      half_done   = (cnt_q == div_q);
      // Even edge index = leading edge, odd = trailing edge.
      sample_edge = (edge_q[0] == cpha_q);
      // Shift on the non-sampling edges, skipping the first leading edge (CPHA=1, the MSB is
      // already on the line) or the last trailing edge (CPHA=0, nothing left to present).
      if (cpha_q) begin
         shift_edge = !edge_q[0] && (edge_q != '0);
      end else begin
         shift_edge = edge_q[0] && (edge_q != LastEdge);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         div_q     <= '0;
         edge_q    <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         sclk_q    <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (i_start) begin
                  state_q <= StSetup;
                  tx_q    <= i_tx_data;
                  cpol_q  <= i_cpol;
                  cpha_q  <= i_cpha;
                  div_q   <= i_div;
                  sclk_q  <= i_cpol;
                  cnt_q   <= '0;
                  edge_q  <= '0;
                  cs_n_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            StSetup: begin
               if (half_done) begin
                  state_q <= StShift;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + DIV_WIDTH'(1);
               end
            end
            StShift: begin
               if (half_done) begin
                  cnt_q  <= '0;
                  sclk_q <= ~sclk_q;
                  // MISO is captured on the same edge that moves SCK to the sampling level.
                  if (sample_edge) begin
                     rx_q <= {rx_q[DATA_WIDTH-2:0], i_miso};
                  end
                  if (shift_edge) begin
                     tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                  end
                  if (edge_q == LastEdge) begin
                     state_q <= StHold;
                     edge_q  <= '0;
                  end else begin
                     edge_q <= edge_q + EdgeW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + DIV_WIDTH'(1);
               end
            end
            StHold: begin
               if (half_done) begin
                  state_q   <= StIdle;
                  cnt_q     <= '0;
                  cs_n_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  rx_data_q <= rx_q;
               end else begin
                  cnt_q <= cnt_q + DIV_WIDTH'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // While idle SCK tracks the live CPOL input so the line sits at the requested idle level.
   assign o_sclk    = (state_q == StIdle) ? i_cpol : sclk_q;
   assign o_mosi    = tx_q[DATA_WIDTH-1];
   assign o_cs_n    = cs_n_q;
   assign o_busy    = busy_q;
   assign o_rx_data = rx_data_q;
   assign o_done    = done_q;

endmodule
